// File: rtl/tm1638_pkg.sv
// Shared constants and state encoding for the TM1638 bus responder.
package tm1638_pkg;

   localparam logic [1:0] CMD_DATA = 2'b01;
   localparam logic [1:0] CMD_DISP = 2'b10;
   localparam logic [1:0] CMD_ADDR = 2'b11;

   localparam int unsigned READ  = 1;
   localparam int unsigned FIXED = 2;

   typedef enum logic [2:0] {
      IDLE,
      CMD,
      WDATA,
      RDATA,
      IGNORE
   } state_t;

endpackage

// File: rtl/tm1638_edge_sync.sv
// N-stage synchronizer with registered rise/fall strobes for one bus line.
module tm1638_edge_sync #(
   parameter int unsigned STAGES = 2,
   parameter logic        INIT   = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] chain;
   logic              prev;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         chain <= {STAGES{INIT}};
         prev  <= INIT;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         chain <= {chain[STAGES-2:0], din};
         prev  <= chain[STAGES-1];
         rise  <= chain[STAGES-1] & ~prev;
         fall  <= ~chain[STAGES-1] & prev;
      end
   end

endmodule

// File: rtl/tm1638_rx.sv
// TM1638 chip-side responder: decodes host frames into display RAM and
// control state, and shifts the key vector out on key-read frames.
module tm1638_rx
   import tm1638_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          tm_stb,
   input  logic          tm_clk,
   input  logic          tm_dio_in,
   output logic          tm_dio_out,
   output logic          tm_dio_oe,
   input  logic [31:0]   keys,
   output logic [127:0]  disp,
   output logic          display_on,
   output logic [2:0]    brightness,
   output logic          frame_done
);

   state_t                 state, state_next;
   logic                   clk_rise, clk_fall, stb_rise, stb_fall;
   logic [SYNC_STAGES-1:0] dio_chain;
   logic                   dio;
   logic [2:0]             bit_cnt;
   logic [7:0]             shreg;
   logic [7:0]             byte_val;
   logic                   byte_done;
   logic                   got_byte;
   logic [3:0]             addr;
   logic                   read_flag, fixed_flag;
   logic [31:0]            tx;
   logic                   bit_taken;
   logic [7:0]             ram [16];

   tm1638_edge_sync #(.STAGES(SYNC_STAGES), .INIT(1'b1)) u_clk_sync (
      .clk(clk), .reset(reset), .din(tm_clk), .rise(clk_rise), .fall(clk_fall)
   );

   tm1638_edge_sync #(.STAGES(SYNC_STAGES), .INIT(1'b1)) u_stb_sync (
      .clk(clk), .reset(reset), .din(tm_stb), .rise(stb_rise), .fall(stb_fall)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) dio_chain <= '1;
      else       dio_chain <= {dio_chain[SYNC_STAGES-2:0], tm_dio_in};
   end
   assign dio = dio_chain[SYNC_STAGES-1];

   assign byte_val  = {dio, shreg[7:1]};
   assign byte_done = (state != IDLE) && clk_rise && !stb_rise && (bit_cnt == 3'd7);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      if (stb_rise) begin
         state_next = IDLE;
      end else begin
         case (state)
            IDLE: if (stb_fall) state_next = CMD;
            CMD: begin
               if (byte_done) begin
                  case (byte_val[7:6])
                     CMD_DATA: state_next = byte_val[READ] ? RDATA : IGNORE;
                     CMD_ADDR: state_next = WDATA;
                     default:  state_next = IGNORE;
                  endcase
               end
            end
            default: state_next = state;
         endcase
      end
   end

   assign tm_dio_oe = (state == RDATA) && !stb_rise;

   // A fall only advances the read bit once the host has clocked the
   // current one with a rise, so bit 0 survives the first fall of the phase.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bit_cnt    <= '0;
         shreg      <= '0;
         got_byte   <= 1'b0;
         addr       <= '0;
         read_flag  <= 1'b0;
         fixed_flag <= 1'b0;
         display_on <= 1'b0;
         brightness <= '0;
         tx         <= '0;
         bit_taken  <= 1'b0;
         tm_dio_out <= 1'b1;
         frame_done <= 1'b0;
         for (int unsigned a = 0; a < 16; a++) ram[a] <= '0;
      end else begin
         frame_done <= stb_rise & got_byte;
         if (stb_rise) begin
            bit_cnt    <= '0;
            got_byte   <= 1'b0;
            bit_taken  <= 1'b0;
            tm_dio_out <= 1'b1;
         end else if (state != IDLE && clk_rise) begin
            shreg   <= byte_val;
            bit_cnt <= bit_cnt + 3'd1;
            if (state == RDATA) bit_taken <= 1'b1;
            if (bit_cnt == 3'd7) begin
               got_byte <= 1'b1;
               case (state)
                  CMD: begin
                     case (byte_val[7:6])
                        CMD_DATA: begin
                           read_flag  <= byte_val[READ];
                           fixed_flag <= byte_val[FIXED];
                           if (byte_val[READ]) begin
                              tx         <= {1'b0, keys[31:1]};
                              tm_dio_out <= keys[0];
                           end
                        end
                        CMD_DISP: begin
                           display_on <= byte_val[3];
                           brightness <= byte_val[2:0];
                        end
                        CMD_ADDR: addr <= byte_val[3:0];
                        default: ;
                     endcase
                  end
                  WDATA: begin
                     ram[addr] <= byte_val;
                     if (!fixed_flag) addr <= addr + 4'd1;
                  end
                  default: ;
               endcase
            end
         end else if (state == RDATA && clk_fall && bit_taken) begin
            tm_dio_out <= tx[0];
            tx         <= {1'b0, tx[31:1]};
            bit_taken  <= 1'b0;
         end
      end
   end

   always_comb begin
      disp = '0;
      for (int unsigned a = 0; a < 16; a++) disp[a*8 +: 8] = ram[a];
   end

   // read_flag is kept as persistent command state; decode uses the fresh bit.
   logic unused_ok;
   assign unused_ok = read_flag;

endmodule

// File: tb/tb_tm1638_rx.sv
// Self-checking bench for tm1638_rx: bit-banged host frames, model RAM,
// and a queue of expected key-read bytes.
module tb_tm1638_rx;

   localparam int HALF = 8;

   logic         clk = 1'b0;
   logic         reset;
   logic         tm_stb, tm_clk, tm_dio_in;
   logic         tm_dio_out, tm_dio_oe;
   logic [31:0]  keys;
   logic [127:0] disp;
   logic         display_on;
   logic [2:0]   brightness;
   logic         frame_done;

   int unsigned  n_tests = 0;
   int unsigned  n_fail  = 0;
   int unsigned  fd_cnt  = 0;
   logic [7:0]   model_ram [16];
   logic [7:0]   tx_bytes  [16];
   logic [7:0]   exp_q [$];

   tm1638_rx #(.SYNC_STAGES(2)) dut (
      .clk(clk), .reset(reset), .tm_stb(tm_stb), .tm_clk(tm_clk),
      .tm_dio_in(tm_dio_in), .tm_dio_out(tm_dio_out), .tm_dio_oe(tm_dio_oe),
      .keys(keys), .disp(disp), .display_on(display_on),
      .brightness(brightness), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (frame_done) fd_cnt <= fd_cnt + 1;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [127:0] exp_disp();
      logic [127:0] v;
      for (int i = 0; i < 16; i++) v[i*8 +: 8] = model_ram[i];
      return v;
   endfunction

   task automatic wait_clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic put_bits(input logic [7:0] b, input int n);
      for (int i = 0; i < n; i++) begin
         tm_clk = 1'b0;
         tm_dio_in = b[i];
         wait_clks(HALF);
         tm_clk = 1'b1;
         wait_clks(HALF);
      end
      tm_dio_in = 1'b1;
   endtask

   task automatic frame_begin();
      tm_stb = 1'b0;
      wait_clks(HALF);
   endtask

   task automatic frame_end();
      wait_clks(HALF);
      tm_stb = 1'b1;
      wait_clks(3*HALF);
   endtask

   task automatic send_frame(input int n);
      frame_begin();
      for (int i = 0; i < n; i++) put_bits(tx_bytes[i], 8);
      frame_end();
   endtask

   task automatic read_bit(output logic b);
      tm_clk = 1'b0;
      wait_clks(HALF);
      b = tm_dio_out;
      tm_clk = 1'b1;
      wait_clks(HALF);
   endtask

   task automatic read_byte(input string tag);
      logic [7:0] got;
      logic       b;
      for (int i = 0; i < 8; i++) begin
         read_bit(b);
         got[i] = b;
      end
      check({tag, "_oe"}, tm_dio_oe, 1'b1);
      check({tag, "_q"}, exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) check(tag, got, exp_q.pop_front());
   endtask

   initial begin
      logic b;
      int   fd0;
      reset = 1'b1; tm_stb = 1'b1; tm_clk = 1'b1; tm_dio_in = 1'b1; keys = '0;
      for (int i = 0; i < 16; i++) model_ram[i] = 8'h00;
      wait_clks(5);
      check("rst_disp", disp, '0);
      check("rst_on", display_on, 1'b0);
      check("rst_bright", brightness, 3'd0);
      check("rst_oe", tm_dio_oe, 1'b0);
      check("rst_dio", tm_dio_out, 1'b1);
      check("rst_fd", frame_done, 1'b0);
      reset = 1'b0;
      wait_clks(4);

      // display writer sequence
      tx_bytes[0] = 8'h8F; send_frame(1);
      tx_bytes[0] = 8'h40; send_frame(1);
      tx_bytes[0] = 8'hC0;
      tx_bytes[1] = 8'h3F; tx_bytes[2]  = 8'h00; tx_bytes[3]  = 8'h06; tx_bytes[4]  = 8'h00;
      tx_bytes[5] = 8'h5B; tx_bytes[6]  = 8'h00; tx_bytes[7]  = 8'h4F; tx_bytes[8]  = 8'h00;
      tx_bytes[9] = 8'h66; tx_bytes[10] = 8'h00; tx_bytes[11] = 8'h6D; tx_bytes[12] = 8'h00;
      tx_bytes[13] = 8'h7D; tx_bytes[14] = 8'h00; tx_bytes[15] = 8'h07;
      send_frame(16);
      for (int i = 0; i < 15; i++) model_ram[i] = tx_bytes[i+1];
      check("wr_on", display_on, 1'b1);
      check("wr_bright", brightness, 3'd7);
      check("wr_disp", disp, exp_disp());
      check("wr_fd", fd_cnt, 3);

      // auto-increment wraps 15 -> 0
      tx_bytes[0] = 8'h40; send_frame(1);
      tx_bytes[0] = 8'hCF; tx_bytes[1] = 8'hAA; tx_bytes[2] = 8'hBB; send_frame(3);
      model_ram[15] = 8'hAA; model_ram[0] = 8'hBB;
      check("wrap_disp", disp, exp_disp());

      // fixed address
      tx_bytes[0] = 8'h44; send_frame(1);
      tx_bytes[0] = 8'hC3; tx_bytes[1] = 8'h11; tx_bytes[2] = 8'h22; send_frame(3);
      model_ram[3] = 8'h22;
      check("fix_disp", disp, exp_disp());
      check("fix_ram4", disp[39:32], 8'h5B);

      // key read
      keys = 32'h80C0_0102;
      check("kr_oe_pre", tm_dio_oe, 1'b0);
      exp_q.push_back(8'h02); exp_q.push_back(8'h01); exp_q.push_back(8'hC0);
      exp_q.push_back(8'h80); exp_q.push_back(8'h00);
      frame_begin();
      put_bits(8'h42, 8);
      check("kr_oe_cmd", tm_dio_oe, 1'b1);
      for (int i = 0; i < 5; i++) read_byte("kr_byte");
      frame_end();
      check("kr_oe_post", tm_dio_oe, 1'b0);
      check("kr_q_left", exp_q.size(), 0);

      // abort mid-byte
      fd0 = fd_cnt;
      frame_begin();
      put_bits(8'hC0, 8);
      put_bits(8'h55, 5);
      frame_end();
      check("ab_disp", disp, exp_disp());
      check("ab_fd", fd_cnt - fd0, 1);
      tx_bytes[0] = 8'h8C; send_frame(1);
      check("ab_on", display_on, 1'b1);
      check("ab_bright", brightness, 3'd4);
      tx_bytes[0] = 8'hC5; tx_bytes[1] = 8'h99; send_frame(2);
      model_ram[5] = 8'h99;
      check("ab_next_disp", disp, exp_disp());

      // reset in the middle of a read (bit 12)
      keys = 32'h1234_5678;
      exp_q.push_back(8'h78);
      frame_begin();
      put_bits(8'h42, 8);
      read_byte("rr_byte");
      for (int i = 0; i < 4; i++) read_bit(b);
      reset = 1'b1;
      #1;
      check("rr_oe", tm_dio_oe, 1'b0);
      check("rr_dio", tm_dio_out, 1'b1);
      check("rr_disp", disp, '0);
      check("rr_on", display_on, 1'b0);
      for (int i = 0; i < 16; i++) model_ram[i] = 8'h00;
      tm_stb = 1'b1; tm_clk = 1'b1;
      wait_clks(4);
      reset = 1'b0;
      wait_clks(3*HALF);
      tx_bytes[0] = 8'h8A; send_frame(1);
      check("rr_bright", brightness, 3'd2);
      check("rr_on2", display_on, 1'b1);
      check("rr_disp2", disp, exp_disp());

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
